viterbi_block_decoder: RTL

VITERBI_BLOCK_DECODER -- requirements
Module: viterbi_block_decoder

---
 rtl/viterbi_block_decoder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_block_decoder.sv
// Hard-decision rate-1/2 block Viterbi decoder: one add-compare-select per
// cycle, full-block survivor storage and a single traceback pass per block.
module viterbi_block_decoder #(
  parameter int               K_LEN      = 7,
  parameter logic [K_LEN-1:0] G0         = 7'o171,
  parameter logic [K_LEN-1:0] G1         = 7'o133,
  parameter int               NBITS      = 120,
  parameter int               METRIC_W   = 8,
  parameter int               TERMINATED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
  input  logic [1:0] in_erase,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam int NSTATES = 1 << (K_LEN - 1);
  localparam int SW      = K_LEN - 1;
  localparam int TW      = $clog2(NBITS);

  localparam logic [METRIC_W-1:0] M_MAX  = '1;
  localparam logic [SW-1:0]       S_LAST = '1;
  localparam logic [TW-1:0]       T_LAST = TW'(NBITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACS, S_TBSEL, S_TB, S_OUT} state_t;

  function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a,
                                                  input logic [1:0] b);
    logic [METRIC_W:0] s;
    s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
    return s[METRIC_W] ? M_MAX : s[METRIC_W-1:0];
  endfunction

  function automatic logic [1:0] branch_metric(input logic [K_LEN-1:0] enc_reg,
                                               input logic [1:0] sym,
                                               input logic [1:0] era);
    logic d0, d1;
    d0 = ~era[0] & (sym[0] ^ (^(G0 & enc_reg)));
    d1 = ~era[1] & (sym[1] ^ (^(G1 & enc_reg)));
    return {d0 & d1, d0 ^ d1};
  endfunction

  function automatic logic [METRIC_W-1:0] start_metric(input logic [SW-1:0] s);
    return (s == '0) ? '0 : M_MAX;
  endfunction

  state_t state_q, state_d;
  logic   idle_wait_q, idle_wait_d;
  logic [TW-1:0] t_q, t_d, oidx_q, oidx_d;
  logic [SW-1:0] idx_q, idx_d, cur_q, cur_d;
  logic          bank_q, bank_d;
  logic [METRIC_W-1:0] prev_min_q, prev_min_d, min_run_q, min_run_d, best_m_q, best_m_d;
  logic [1:0]    sym_q, sym_d, era_q, era_d;
  logic [NBITS-1:0] dec_q, dec_d;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic out_bit_q, out_bit_d, out_last_q, out_last_d, busy_q, busy_d;

  logic [METRIC_W-1:0] pm_mem [2][NSTATES];
  logic [NSTATES-1:0]  surv_mem [NBITS];

  logic [SW-1:0]       pred0, pred1;
  logic                u_bit, take1, tb_surv;
  logic [METRIC_W-1:0] old0, old1, cand0, cand1, best_cand, acs_new, scan_m;

  // ACS datapath for target state idx_q; step 0 sees the block-start metrics
  assign u_bit     = idx_q[SW-1];
  assign pred0     = {idx_q[SW-2:0], 1'b0};
  assign pred1     = {idx_q[SW-2:0], 1'b1};
  assign old0      = (t_q == '0) ? start_metric(pred0) : pm_mem[bank_q][pred0];
  assign old1      = (t_q == '0) ? start_metric(pred1) : pm_mem[bank_q][pred1];
  assign cand0     = sat_add(old0, branch_metric({u_bit, pred0}, sym_q, era_q));
  assign cand1     = sat_add(old1, branch_metric({u_bit, pred1}, sym_q, era_q));
  assign take1     = cand1 < cand0;
  assign best_cand = take1 ? cand1 : cand0;
  assign acs_new   = best_cand - prev_min_q;
  assign scan_m    = pm_mem[bank_q][idx_q];
  assign tb_surv   = surv_mem[t_q][cur_q];

  always_comb begin
    state_d     = state_q;
    idle_wait_d = 1'b0;
    t_d         = t_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    prev_min_d  = prev_min_q;
    min_run_d   = min_run_q;
    sym_d       = sym_q;
    era_d       = era_q;
    cur_d       = cur_q;
    best_m_d    = best_m_q;
    dec_d       = dec_q;
    oidx_d      = oidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (!idle_wait_q) begin
          state_d    = S_LOAD;
          t_d        = '0;
          prev_min_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          sym_d   = in_sym;
          era_d   = in_erase;
          idx_d   = '0;
          state_d = S_ACS;
        end
      end
      S_ACS: begin
        idx_d     = idx_q + SW'(1);
        min_run_d = (idx_q == '0 || acs_new < min_run_q) ? acs_new : min_run_q;
        if (idx_q == S_LAST) begin
          prev_min_d = min_run_d;
          bank_d     = ~bank_q;
          idx_d      = '0;
          if (t_q != T_LAST) begin
            t_d     = t_q + TW'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_TBSEL;
          end
        end
      end
      S_TBSEL: begin
        if (TERMINATED != 0) begin
          cur_d   = '0;
          t_d     = T_LAST;
          state_d = S_TB;
        end else begin
          idx_d = idx_q + SW'(1);
          if (idx_q == '0 || scan_m < best_m_q) begin
            best_m_d = scan_m;
            cur_d    = idx_q;
          end
          if (idx_q == S_LAST) begin
            idx_d   = '0;
            t_d     = T_LAST;
            state_d = S_TB;
          end
        end
      end
      S_TB: begin
        dec_d[t_q] = cur_q[SW-1];
        cur_d      = {cur_q[SW-2:0], tb_surv};
        if (t_q == '0) begin
          oidx_d  = '0;
          state_d = S_OUT;
        end else begin
          t_d = t_q - TW'(1);
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            t_d        = '0;
            prev_min_d = '0;
            state_d    = S_LOAD;
          end else begin
            oidx_d = oidx_q + TW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_OUT);
    out_bit_d   = out_valid_d & dec_d[oidx_d];
    out_last_d  = out_valid_d && (oidx_d == T_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idle_wait_q <= 1'b1;
      t_q         <= '0;
      idx_q       <= '0;
      oidx_q      <= '0;
      bank_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_wait_q <= idle_wait_d;
      t_q         <= t_d;
      idx_q       <= idx_d;
      oidx_q      <= oidx_d;
      bank_q      <= bank_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_min_q <= prev_min_d;
    min_run_q  <= min_run_d;
    sym_q      <= sym_d;
    era_q      <= era_d;
    cur_q      <= cur_d;
    best_m_q   <= best_m_d;
    dec_q      <= dec_d;
  end

  // Metric banks swap per step: read bank_q, write the other one
  always_ff @(posedge clk) begin
    if (state_q == S_ACS) begin
      pm_mem[~bank_q][idx_q] <= acs_new;
      surv_mem[t_q][idx_q]   <= take1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule
